cv32e40p_x_dispatch: RTL and testbench
======================================

Name: cv32e40p_x_dispatch

Overview:
- Parametrised successor to the single-accelerator X-interface wrapper. Dispatches offloaded X-request transactions from the core to one of NumAcc accelerator channels.
- Channel selection is by per-channel opcode mask/match predecode.
- Tracks outstanding transactions per channel and pending destination registers (WAW guard). Arbitrates accelerator responses round-robin back onto the single X-response channel.
- Sits between the core X-interface ports and the accelerator subsystems (FPU and others).

Parameters:
- NumAcc, 2, number of accelerator channels (1..8).
- MaxOutstanding, 4, maximum in-flight transactions per channel (1..15).
- AccMask, all-ones, NumAcc x 32 packed; instruction bit mask per channel.
- AccMatch, zero, NumAcc x 32 packed; match value per channel.
- AccRsMask, 3'b011 per channel, NumAcc x 3 packed; which rs_valid bits the channel requires.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- x_q_valid_i  in  1  request valid
- x_q_ready_o  out  1  request ready
- x_q_instr_data_i  in  32  instruction
- x_q_rs_i  in  3x32  operands
- x_q_rs_valid_i  in  3  operand valid
- x_k_accept_o  out  1  instruction accepted (valid when x_q_valid_i&x_q_ready_o)
- x_k_writeback_o  out  1  accepted and rd!=0
- x_p_valid_o  out  1  response valid
- x_p_ready_i  in  1  response ready
- x_p_rd_o  out  5  destination register
- x_p_data_o  out  32  result
- x_p_dualwb_o  out  1  dual writeback flag
- x_p_error_o  out  1  error flag
- acc_q_valid_o  out  NumAcc  per-channel request valid
- acc_q_ready_i  in  NumAcc  per-channel request ready
- acc_q_instr_data_o  out  32  broadcast instruction
- acc_q_rs_o  out  3x32  broadcast operands
- acc_p_valid_i  in  NumAcc  per-channel response valid
- acc_p_ready_o  out  NumAcc  per-channel response ready
- acc_p_rd_i  in  NumAcc x 5  per-channel rd
- acc_p_data_i  in  NumAcc x 32  per-channel data
- acc_p_dualwb_i  in  NumAcc  per-channel dualwb
- acc_p_error_i  in  NumAcc  per-channel error

Behaviour:
- Clock and reset: single clock clk_i; rst_ni asynchronous, active-low.
- Reset state: all outstanding counters 0, pending-rd vector 0, round-robin pointer 0, grant lock clear. Consequently x_p_valid_o=0, acc_q_valid_o=0, acc_p_ready_o=0, x_k_accept_o=0, x_k_writeback_o=0.
- Predecode (combinational): match[i] = ((instr & AccMask[i]) == AccMatch[i]). sel = lowest-index matching channel; hit = |match.
- rd = instr[11:7].
- stall = counter[sel]==MaxOutstanding, OR (rd!=0 AND pending[rd]), OR ((x_q_rs_valid_i & AccRsMask[sel]) != AccRsMask[sel]).
- No hit: x_q_ready_o=1, x_k_accept_o=0; transaction rejected in the same cycle; no state change.
- Hit: acc_q_valid_o[sel] = x_q_valid_i & ~stall. x_q_ready_o = acc_q_ready_i[sel] & ~stall. x_k_accept_o=1. x_k_writeback_o = (rd!=0).
- Issue handshake (x_q_valid_i & x_q_ready_o & hit): counter[sel]++. If rd!=0, pending[rd] is set.
- Response arbitration: round-robin over acc_p_valid_i, starting at the pointer.
  - Granted channel drives the x_p_* outputs; acc_p_ready_o[g] = x_p_ready_i.
  - While x_p_valid_o & ~x_p_ready_i, the grant is locked (no switching; outputs stable).
  - On response handshake: counter[g]--, pending[acc_p_rd_i[g]] cleared (rd 0 ignored), pointer = g+1 mod NumAcc.
- Same-channel issue and response in one cycle: counter unchanged. Same-rd set/clear conflict cannot occur (WAW stall). Clear and set of different bits in one cycle both apply.
- Counter underflow: a response on a channel with counter 0 is a protocol violation; simulation assertion fires and the counter saturates at 0.
- Latency: request path combinational (0 cycles); response path 0 cycles without the optional feature.
- Reset mid-operation: all tracking state cleared immediately; in-flight accelerator responses after reset must be discarded by the accelerators' own reset.

Optional Feature:
- CV_X_RSP_REG_EN defined: a 2-entry spill register sits between the arbiter and the x_p_* outputs. Response latency is +1 cycle and back-to-back throughput is kept.
  - The spill register is reset to empty.
  - Counters and pending bits update on the accelerator-side handshake (arbiter into spill register).
- Undefined: arbiter output drives x_p_* combinationally; counters and pending bits update on the x_p handshake.

Test Plan:
- Reject: instr 0x0000_0013, no channel match -> x_q_ready_o=1, x_k_accept_o=0, all acc_q_valid_o=0, state unchanged.
- Dispatch: instr matching channel 1 only, rd=5, rs_valid=3'b011 -> acc_q_valid_o=2'b10, accept=1, writeback=1, counter[1]=1, pending[5]=1.
- Outstanding limit: MaxOutstanding=4, five issues to channel 0 with no responses -> fifth held with x_q_ready_o=0 until one response handshakes, then it is accepted in that cycle.
- WAW: pending[7]=1; new instr with rd=7 -> stalled; after a response with rd=7, the instr is issued next cycle. rd=0 instr is never stalled by pending state.
- Round-robin and lock: both channels valid continuously, x_p_ready_i low 3 cycles -> outputs stable on ch0. Then grants alternate 0,1,0,1 with ready high.
- CV_X_RSP_REG_EN: single response -> x_p_valid_o rises 1 cycle after acc_p_valid_i. Continuous responses with ready high -> one per cycle.

Source files
------------

// File: rtl/cv32e40p_x_dispatch.sv
// ----------------------------------------------------------------------------
// cv32e40p_x_dispatch
//
// Dispatches X-interface offload requests from the core to one of NumAcc
// accelerator channels and merges their responses back onto the single core
// response channel.
//
// Request side:
//   x_q_*   core request (valid/ready, instruction, operands, operand valids)
//   x_k_*   accept / writeback indication for the presented instruction
//   acc_q_* per-channel request valid/ready, broadcast instruction and operands
// Response side:
//   acc_p_* per-channel responses (valid/ready, rd, data, dualwb, error)
//   x_p_*   merged core response
//
// Channel selection: channel i matches when (instr & AccMask[i]) == AccMatch[i];
// the lowest matching index wins. Per-channel outstanding counters cap the
// in-flight transactions at MaxOutstanding, and a pending-rd vector stalls
// any instruction whose rd is still owed a result (WAW guard).
//
// Responses are arbitrated round-robin starting at a rotating pointer. While
// the granted response is stalled the grant is held so the outputs stay stable.
//
// Optional build macro CV_X_RSP_REG_EN: inserts a 2-entry spill register
// between the arbiter and the x_p_* outputs (+1 cycle latency, full
// throughput). Tracking state then updates on the arbiter-side handshake.
// ----------------------------------------------------------------------------
module cv32e40p_x_dispatch #(
    parameter int unsigned                NumAcc         = 2,
    parameter int unsigned                MaxOutstanding = 4,
    parameter logic [NumAcc-1:0][31:0]    AccMask        = '1,
    parameter logic [NumAcc-1:0][31:0]    AccMatch       = '0,
    parameter logic [NumAcc-1:0][2:0]     AccRsMask      = {NumAcc{3'b011}}
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic                          x_q_valid_i,
    output logic                          x_q_ready_o,
    input  logic [31:0]                   x_q_instr_data_i,
    input  logic [2:0][31:0]              x_q_rs_i,
    input  logic [2:0]                    x_q_rs_valid_i,
    output logic                          x_k_accept_o,
    output logic                          x_k_writeback_o,

    output logic                          x_p_valid_o,
    input  logic                          x_p_ready_i,
    output logic [4:0]                    x_p_rd_o,
    output logic [31:0]                   x_p_data_o,
    output logic                          x_p_dualwb_o,
    output logic                          x_p_error_o,

    output logic [NumAcc-1:0]             acc_q_valid_o,
    input  logic [NumAcc-1:0]             acc_q_ready_i,
    output logic [31:0]                   acc_q_instr_data_o,
    output logic [2:0][31:0]              acc_q_rs_o,

    input  logic [NumAcc-1:0]             acc_p_valid_i,
    output logic [NumAcc-1:0]             acc_p_ready_o,
    input  logic [NumAcc-1:0][4:0]        acc_p_rd_i,
    input  logic [NumAcc-1:0][31:0]       acc_p_data_i,
    input  logic [NumAcc-1:0]             acc_p_dualwb_i,
    input  logic [NumAcc-1:0]             acc_p_error_i
);

    localparam int IdxW = (NumAcc > 1) ? $clog2(NumAcc) : 1;
    localparam int CntW = 4;

    logic [NumAcc-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [31:0]                 pending_q, pending_d;
    logic [IdxW-1:0]             ptr_q, ptr_d;
    logic                        lock_q, lock_d;
    logic [IdxW-1:0]             lock_idx_q;

    logic [NumAcc-1:0]           match;
    logic                        hit;
    logic [IdxW-1:0]             sel;
    logic [4:0]                  rd;
    logic [2:0]                  rs_req;
    logic                        stall;
    logic                        issue;
    logic [NumAcc-1:0]           inc, dec;

    logic [IdxW-1:0]             rr_idx, arb_grant;
    logic                        arb_valid, arb_ready, rsp_fire;
    logic [4:0]                  rsp_rd;
    logic [31:0]                 set_vec, clr_vec;

    assign acc_q_instr_data_o = x_q_instr_data_i;
    assign acc_q_rs_o         = x_q_rs_i;
    assign rd                 = x_q_instr_data_i[11:7];

    // ------------------------------------------------------------------
    // Predecode and issue
    // ------------------------------------------------------------------
    always_comb begin
        match = '0;
        sel   = '0;
        for (int i = 0; i < int'(NumAcc); i++) begin
            match[i] = ((x_q_instr_data_i & AccMask[i]) == AccMatch[i]);
        end
        for (int i = int'(NumAcc) - 1; i >= 0; i--) begin
            if (match[i]) sel = IdxW'(i);
        end
        hit = |match;
    end

    // A response retiring on the selected channel in this cycle frees a slot,
    // so a full channel can take a new request in the same cycle.
    always_comb begin
        rs_req = AccRsMask[sel];
        stall  = ((cnt_q[sel] == CntW'(MaxOutstanding)) && !dec[sel])
               || ((rd != 5'd0) && pending_q[rd])
               || ((x_q_rs_valid_i & rs_req) != rs_req);

        acc_q_valid_o = '0;
        x_q_ready_o   = 1'b1;
        if (hit) begin
            acc_q_valid_o[sel] = x_q_valid_i & ~stall;
            x_q_ready_o        = acc_q_ready_i[sel] & ~stall;
        end
        x_k_accept_o    = x_q_valid_i & hit;
        x_k_writeback_o = x_q_valid_i & hit & (rd != 5'd0);
        issue           = x_q_valid_i & x_q_ready_o & hit;
    end

    // ------------------------------------------------------------------
    // Response arbitration
    // ------------------------------------------------------------------
    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        rr_idx = ptr_q;
        for (int k = 0; k < int'(NumAcc); k++) begin
            idx = (int'(ptr_q) + k) % int'(NumAcc);
            if (!found && acc_p_valid_i[idx]) begin
                rr_idx = IdxW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign arb_grant = lock_q ? lock_idx_q : rr_idx;
    assign arb_valid = acc_p_valid_i[arb_grant];
    assign rsp_fire  = arb_valid & arb_ready;
    assign rsp_rd    = acc_p_rd_i[arb_grant];
    assign lock_d    = arb_valid & ~arb_ready;

    always_comb begin
        acc_p_ready_o            = '0;
        acc_p_ready_o[arb_grant] = arb_valid & arb_ready;
    end

    // ------------------------------------------------------------------
    // Tracking state next values
    // ------------------------------------------------------------------
    always_comb begin
        inc     = '0;
        dec     = '0;
        set_vec = '0;
        clr_vec = '0;
        ptr_d   = ptr_q;
        if (issue) inc[sel] = 1'b1;
        if (rsp_fire) begin
            dec[arb_grant] = 1'b1;
            ptr_d          = IdxW'((int'(arb_grant) + 1) % int'(NumAcc));
        end
        if (issue && (rd != 5'd0))        set_vec[rd]     = 1'b1;
        if (rsp_fire && (rsp_rd != 5'd0)) clr_vec[rsp_rd] = 1'b1;
        pending_d = (pending_q & ~clr_vec) | set_vec;

        for (int i = 0; i < int'(NumAcc); i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            pending_q  <= '0;
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= arb_grant;
        end
    end

`ifndef SYNTHESIS
    // A response on a channel with nothing outstanding is an accelerator bug.
    underflow_chk : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_fire |-> (cnt_q[arb_grant] != '0));
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef CV_X_RSP_REG_EN
    logic [1:0][4:0]  sp_rd_q;
    logic [1:0][31:0] sp_data_q;
    logic [1:0]       sp_dualwb_q, sp_error_q;
    logic             sp_wr_q, sp_rd_ptr_q;
    logic [1:0]       sp_cnt_q;
    logic             sp_pop;

    // Accepting only when not full still sustains one response per cycle,
    // since in steady state the register holds a single entry.
    assign arb_ready    = (sp_cnt_q != 2'd2);
    assign x_p_valid_o  = (sp_cnt_q != 2'd0);
    assign x_p_rd_o     = sp_rd_q[sp_rd_ptr_q];
    assign x_p_data_o   = sp_data_q[sp_rd_ptr_q];
    assign x_p_dualwb_o = sp_dualwb_q[sp_rd_ptr_q];
    assign x_p_error_o  = sp_error_q[sp_rd_ptr_q];
    assign sp_pop       = x_p_valid_o & x_p_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_rd_q     <= '0;
            sp_data_q   <= '0;
            sp_dualwb_q <= '0;
            sp_error_q  <= '0;
            sp_wr_q     <= 1'b0;
            sp_rd_ptr_q <= 1'b0;
            sp_cnt_q    <= 2'd0;
        end else begin
            if (rsp_fire) begin
                sp_rd_q[sp_wr_q]     <= rsp_rd;
                sp_data_q[sp_wr_q]   <= acc_p_data_i[arb_grant];
                sp_dualwb_q[sp_wr_q] <= acc_p_dualwb_i[arb_grant];
                sp_error_q[sp_wr_q]  <= acc_p_error_i[arb_grant];
                sp_wr_q              <= ~sp_wr_q;
            end
            if (sp_pop) sp_rd_ptr_q <= ~sp_rd_ptr_q;
            unique case ({rsp_fire, sp_pop})
                2'b10:   sp_cnt_q <= sp_cnt_q + 2'd1;
                2'b01:   sp_cnt_q <= sp_cnt_q - 2'd1;
                default: sp_cnt_q <= sp_cnt_q;
            endcase
        end
    end
`else
    assign arb_ready    = x_p_ready_i;
    assign x_p_valid_o  = arb_valid;
    assign x_p_rd_o     = rsp_rd;
    assign x_p_data_o   = acc_p_data_i[arb_grant];
    assign x_p_dualwb_o = acc_p_dualwb_i[arb_grant];
    assign x_p_error_o  = acc_p_error_i[arb_grant];
`endif

endmodule

// File: tb/tb_cv32e40p_x_dispatch.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_x_dispatch
//
// Directed bench for cv32e40p_x_dispatch with two channels:
//   channel 0 decodes opcode 0x0B, channel 1 decodes opcode 0x2B.
// Responses are expected in a queue filled when they are driven and drained
// when the core-side handshake is seen. Builds with or without
// CV_X_RSP_REG_EN.
// ----------------------------------------------------------------------------
module tb_cv32e40p_x_dispatch;

`ifdef CV_X_RSP_REG_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             x_q_valid_i;
    logic             x_q_ready_o;
    logic [31:0]      x_q_instr_data_i;
    logic [2:0][31:0] x_q_rs_i;
    logic [2:0]       x_q_rs_valid_i;
    logic             x_k_accept_o;
    logic             x_k_writeback_o;
    logic             x_p_valid_o;
    logic             x_p_ready_i;
    logic [4:0]       x_p_rd_o;
    logic [31:0]      x_p_data_o;
    logic             x_p_dualwb_o;
    logic             x_p_error_o;
    logic [1:0]       acc_q_valid_o;
    logic [1:0]       acc_q_ready_i;
    logic [31:0]      acc_q_instr_data_o;
    logic [2:0][31:0] acc_q_rs_o;
    logic [1:0]       acc_p_valid_i;
    logic [1:0]       acc_p_ready_o;
    logic [1:0][4:0]  acc_p_rd_i;
    logic [1:0][31:0] acc_p_data_i;
    logic [1:0]       acc_p_dualwb_i;
    logic [1:0]       acc_p_error_i;

    cv32e40p_x_dispatch #(
        .NumAcc         (2),
        .MaxOutstanding (4),
        .AccMask        ({32'h0000_007F, 32'h0000_007F}),
        .AccMatch       ({32'h0000_002B, 32'h0000_000B}),
        .AccRsMask      ({3'b011, 3'b011})
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .x_q_valid_i        (x_q_valid_i),
        .x_q_ready_o        (x_q_ready_o),
        .x_q_instr_data_i   (x_q_instr_data_i),
        .x_q_rs_i           (x_q_rs_i),
        .x_q_rs_valid_i     (x_q_rs_valid_i),
        .x_k_accept_o       (x_k_accept_o),
        .x_k_writeback_o    (x_k_writeback_o),
        .x_p_valid_o        (x_p_valid_o),
        .x_p_ready_i        (x_p_ready_i),
        .x_p_rd_o           (x_p_rd_o),
        .x_p_data_o         (x_p_data_o),
        .x_p_dualwb_o       (x_p_dualwb_o),
        .x_p_error_o        (x_p_error_o),
        .acc_q_valid_o      (acc_q_valid_o),
        .acc_q_ready_i      (acc_q_ready_i),
        .acc_q_instr_data_o (acc_q_instr_data_o),
        .acc_q_rs_o         (acc_q_rs_o),
        .acc_p_valid_i      (acc_p_valid_i),
        .acc_p_ready_o      (acc_p_ready_o),
        .acc_p_rd_i         (acc_p_rd_i),
        .acc_p_data_i       (acc_p_data_i),
        .acc_p_dualwb_i     (acc_p_dualwb_i),
        .acc_p_error_i      (acc_p_error_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } rsp_t;

    rsp_t       exp_q[$];
    int         rem[2];
    logic [4:0] rsp_rd[2];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdat(input int c, input int k);
        return 32'hA000_0000 | 32'(c << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] mk(input int ch, input int r);
        return 32'(r << 7) | ((ch == 1) ? 32'h2B : 32'h0B);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int c, input int k);
        rsp_t e;
        e.rd   = rsp_rd[c];
        e.data = rdat(c, k);
        exp_q.push_back(e);
    endtask

    task automatic issue(input string tag, input logic [31:0] instr, input logic [2:0] rsv,
                         input logic exp_rdy, input logic [1:0] exp_av,
                         input logic exp_acc, input logic exp_wb);
        x_q_valid_i      = 1'b1;
        x_q_instr_data_i = instr;
        x_q_rs_valid_i   = rsv;
        x_q_rs_i         = {instr ^ 32'h3333_0000, instr ^ 32'h2222_0000, instr ^ 32'h1111_0000};
        #1;
        check({tag, "_ready"},  {31'd0, x_q_ready_o},     {31'd0, exp_rdy});
        check({tag, "_accv"},   {30'd0, acc_q_valid_o},   {30'd0, exp_av});
        check({tag, "_accept"}, {31'd0, x_k_accept_o},    {31'd0, exp_acc});
        check({tag, "_wb"},     {31'd0, x_k_writeback_o}, {31'd0, exp_wb});
        check({tag, "_instr"},  acc_q_instr_data_o,       instr);
        check({tag, "_rs1"},    acc_q_rs_o[1],            instr ^ 32'h2222_0000);
        tick();
        x_q_valid_i = 1'b0;
    endtask

    // Drives one response on channel c while the caller holds a request.
    task automatic rsp_with_req(input string tag, input int c, input logic [4:0] r,
                                input logic [31:0] d, input logic exp_rdy,
                                input logic [1:0] exp_av);
        rsp_t e;
        logic [1:0] m;
        m = 2'b01 << c;
        acc_p_valid_i[c] = 1'b1;
        acc_p_rd_i[c]    = r;
        acc_p_data_i[c]  = d;
        x_p_ready_i      = 1'b1;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
        @(negedge clk_i);
        check({tag, "_ready"},  {31'd0, x_q_ready_o},   {31'd0, exp_rdy});
        check({tag, "_accv"},   {30'd0, acc_q_valid_o}, {30'd0, exp_av});
        check({tag, "_accrdy"}, {30'd0, acc_p_ready_o}, {30'd0, m});
`ifndef CV_X_RSP_REG_EN
        check({tag, "_xpv"}, {31'd0, x_p_valid_o}, 32'd1);
        if (x_p_valid_o && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_rd"},   {27'd0, x_p_rd_o}, {27'd0, e.rd});
            check({tag, "_data"}, x_p_data_o,        e.data);
        end
`endif
        tick();
        acc_p_valid_i = 2'b00;
    endtask

    // Plays the accelerators: channel c returns rem[c] responses back to back.
    // x_p_ready_i is held low for the first `hold` cycles.
    task automatic drain(input string tag, input bit lat_chk, input int hold,
                         input int max_cyc, input int exp_cyc);
        int         n;
        logic [1:0] hs;
        rsp_t       e;
        n = 0;
        while ((rem[0] != 0 || rem[1] != 0 || exp_q.size() != 0) && n < max_cyc) begin
            x_p_ready_i = (n >= hold);
            for (int c = 0; c < 2; c++) begin
                acc_p_valid_i[c] = (rem[c] != 0);
                acc_p_rd_i[c]    = rsp_rd[c];
                acc_p_data_i[c]  = rdat(c, rem[c]);
            end
            @(negedge clk_i);
            hs = acc_p_valid_i & acc_p_ready_o;
            if (lat_chk && n == 0)
                check({tag, "_latency"}, {31'd0, x_p_valid_o}, (Lat == 0) ? 32'd1 : 32'd0);
            if (x_p_valid_o && x_p_ready_i) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected"}, {31'd0, x_p_valid_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_rd"},   {27'd0, x_p_rd_o}, {27'd0, e.rd});
                    check({tag, "_data"}, x_p_data_o,        e.data);
                end
            end else if (n < hold) begin
`ifndef CV_X_RSP_REG_EN
                check({tag, "_lock_valid"},  {31'd0, x_p_valid_o},   32'd1);
                check({tag, "_lock_accrdy"}, {30'd0, acc_p_ready_o}, 32'd0);
`endif
                if (x_p_valid_o && exp_q.size() != 0)
                    check({tag, "_lock_data"}, x_p_data_o, exp_q[0].data);
            end
            tick();
            for (int c = 0; c < 2; c++) if (hs[c]) rem[c]--;
            n++;
        end
        acc_p_valid_i = 2'b00;
        x_p_ready_i   = 1'b1;
        check({tag, "_done"}, 32'(exp_q.size() + rem[0] + rem[1]), 32'd0);
        if (exp_cyc >= 0) check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        x_q_valid_i      = 1'b0;
        x_q_instr_data_i = '0;
        x_q_rs_i         = '0;
        x_q_rs_valid_i   = 3'b000;
        x_p_ready_i      = 1'b1;
        acc_q_ready_i    = 2'b11;
        acc_p_valid_i    = 2'b00;
        acc_p_rd_i       = '0;
        acc_p_data_i     = '0;
        acc_p_dualwb_i   = 2'b00;
        acc_p_error_i    = 2'b00;
        rem[0] = 0; rem[1] = 0;
        rsp_rd[0] = 5'd0; rsp_rd[1] = 5'd0;

        #22;
        check("rst_xpv",    {31'd0, x_p_valid_o},     32'd0);
        check("rst_accqv",  {30'd0, acc_q_valid_o},   32'd0);
        check("rst_accprd", {30'd0, acc_p_ready_o},   32'd0);
        check("rst_accept", {31'd0, x_k_accept_o},    32'd0);
        check("rst_wb",     {31'd0, x_k_writeback_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Reject, dispatch, rd=0 bypass of pending, operand and ready gating.
        issue("reject", 32'h0000_0013, 3'b011, 1'b1, 2'b00, 1'b0, 1'b0);
        issue("disp",   mk(1, 5),      3'b011, 1'b1, 2'b10, 1'b1, 1'b1);
        issue("waw5",   mk(0, 5),      3'b011, 1'b0, 2'b00, 1'b1, 1'b1);
        issue("rd0",    mk(0, 0),      3'b011, 1'b1, 2'b01, 1'b1, 1'b0);
        issue("rsmiss", mk(0, 0),      3'b001, 1'b0, 2'b00, 1'b1, 1'b0);
        acc_q_ready_i = 2'b01;
        issue("accbp",  mk(1, 0),      3'b011, 1'b0, 2'b10, 1'b1, 1'b0);
        acc_q_ready_i = 2'b11;

        rsp_rd[0] = 5'd0; rem[0] = 1; push(0, 1);
        drain("rsp0", 1'b1, 0, 20, 1 + Lat);
        rsp_rd[1] = 5'd5; rem[1] = 1; push(1, 1);
        drain("rsp1", 1'b1, 0, 20, 1 + Lat);
        issue("rd5_free", mk(0, 5), 3'b011, 1'b1, 2'b01, 1'b1, 1'b1);
        rsp_rd[0] = 5'd5; rem[0] = 1; push(0, 1);
        drain("rsp0b", 1'b0, 0, 20, -1);

        // Outstanding limit on channel 0.
        for (int k = 0; k < 4; k++)
            issue("out", mk(0, 0), 3'b011, 1'b1, 2'b01, 1'b1, 1'b0);
        issue("out5_stall", mk(0, 0), 3'b011, 1'b0, 2'b00, 1'b1, 1'b0);
        x_q_valid_i      = 1'b1;
        x_q_instr_data_i = mk(0, 0);
        x_q_rs_valid_i   = 3'b011;
        rsp_with_req("out5", 0, 5'd0, rdat(0, 9), 1'b1, 2'b01);
        x_q_valid_i = 1'b0;
        issue("out6_stall", mk(0, 0), 3'b011, 1'b0, 2'b00, 1'b1, 1'b0);
        rsp_rd[0] = 5'd0; rem[0] = 4;
        for (int k = 4; k >= 1; k--) push(0, k);
        drain("outdrain", 1'b0, 0, 30, -1);

        // WAW guard on rd 7.
        issue("waw_set",   mk(0, 7), 3'b011, 1'b1, 2'b01, 1'b1, 1'b1);
        issue("waw_stall", mk(1, 7), 3'b011, 1'b0, 2'b00, 1'b1, 1'b1);
        x_q_valid_i      = 1'b1;
        x_q_instr_data_i = mk(1, 7);
        x_q_rs_valid_i   = 3'b011;
        rsp_with_req("waw_clr", 0, 5'd7, rdat(0, 7), 1'b0, 2'b00);
        issue("waw_go",    mk(1, 7), 3'b011, 1'b1, 2'b10, 1'b1, 1'b1);
        rsp_rd[1] = 5'd7; rem[1] = 1; push(1, 1);
        drain("wawdrain", 1'b0, 0, 20, -1);

        // Round-robin with the response held for three cycles.
        issue("rr_a", mk(0, 0), 3'b011, 1'b1, 2'b01, 1'b1, 1'b0);
        issue("rr_b", mk(0, 0), 3'b011, 1'b1, 2'b01, 1'b1, 1'b0);
        issue("rr_c", mk(1, 0), 3'b011, 1'b1, 2'b10, 1'b1, 1'b0);
        issue("rr_d", mk(1, 0), 3'b011, 1'b1, 2'b10, 1'b1, 1'b0);
        rsp_rd[0] = 5'd3; rsp_rd[1] = 5'd4;
        rem[0] = 2; rem[1] = 2;
        push(0, 2); push(1, 2); push(0, 1); push(1, 1);
        drain("rr", 1'b0, 3, 40, 7);

        // Back-to-back responses from one channel.
        for (int k = 0; k < 3; k++)
            issue("b2b", mk(1, 0), 3'b011, 1'b1, 2'b10, 1'b1, 1'b0);
        rsp_rd[1] = 5'd0; rem[1] = 3;
        push(1, 3); push(1, 2); push(1, 1);
        drain("b2b", 1'b1, 0, 20, 3 + Lat);

        // Reset in the middle of operation clears pending state.
        issue("pre_rst", mk(0, 9), 3'b011, 1'b1, 2'b01, 1'b1, 1'b1);
        issue("pre_rst_waw", mk(1, 9), 3'b011, 1'b0, 2'b00, 1'b1, 1'b1);
        rst_ni = 1'b0;
        #2;
        check("mid_rst_xpv",   {31'd0, x_p_valid_o},   32'd0);
        check("mid_rst_accqv", {30'd0, acc_q_valid_o}, 32'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        issue("post_rst", mk(1, 9), 3'b011, 1'b1, 2'b10, 1'b1, 1'b1);
        rsp_rd[1] = 5'd9; rem[1] = 1; push(1, 1);
        drain("post_rst", 1'b1, 0, 20, 1 + Lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
